uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver: 8N1 frames on a single input line → parallel byte plus a one-cycle `ready` strobe.
- Produces the byte/strobe interface that `indicator` and other byte consumers sit on: `data[7:0]` is stable whenever `ready` is high.
- Sits between the board RX pin and the byte consumer, in the single system clock domain.

Parameters:
- CLKS_PER_BIT, 104, system clocks per UART bit (12 MHz / 115200); legal range ≥ 4.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  asynchronous, active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- data  output  8  last correctly received byte
- ready  output  1  one-cycle strobe: `data` just updated
- frame_err  output  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Reset (reset=0, async assert, sync-release safe):
  - data=8'h00, ready=0, frame_err=0.
  - State=IDLE, counters=0.
  - Synchronizer flops preset to 1, so no false start after release.
- Input synchronization: rx passes through a 2-flop synchronizer (rx_s); this adds 2 cycles of fixed latency. All decisions use rx_s.
- Bit timer: counter of width $clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1 and then wrapping.
- Bit index: 3-bit counter.
- FSM states and transitions:
  - IDLE: rx_s==0 → START, bit timer cleared.
  - START: when timer reaches CLKS_PER_BIT/2 - 1 (mid start bit), sample rx_s:
    - 1 → false start (glitch), go to IDLE, no strobe.
    - 0 → go to DATA, timer cleared, bit index=0.
  - DATA: every CLKS_PER_BIT cycles (mid bit), shift rx_s into bit[index], LSB first. After index 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s:
    - 1 → data ← shift register; ready=1 for exactly one cycle; → IDLE.
    - 0 → frame_err=1 for one cycle; data unchanged; → BREAK.
  - BREAK: wait for rx_s==1, then → IDLE. A held-low line (break) must not retrigger reception.
- Latency: ready rises 1 clk after the mid-stop-bit sample, i.e. about 9.5 bit times + 3 clks after the falling edge of the start bit.
- Back-to-back frames: a new start bit is accepted as soon as IDLE is re-entered (half a stop bit early), so frames with minimum 1-stop-bit spacing never drop a byte.
- ready and frame_err are never high in the same cycle.
- data holds its value between strobes.
- Reset mid-frame: the partial byte is discarded, outputs return to reset values, and no strobe is issued.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows bit 7; FSM gains a PARITY state between DATA and STOP.
  - Adds output `parity_err` (1 bit, reset 0).
  - On parity mismatch with a good stop bit: parity_err pulses 1 cycle instead of ready, and data is unchanged.
  - A bad stop bit takes priority: frame_err is reported and parity_err stays 0.
- Undefined: pure 8N1 behaviour; no PARITY state and no parity_err port.

Decomposition:
- Package uart_pkg:
  - FSM state enum {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - DATA_BITS=8.
  - DEFAULT_CLKS_PER_BIT=104.
  - Shared by the future uart_tx.
- Sub-module rx_sync: a 2-flop synchronizer with reset preset value parameter.
  - Reused for other async board inputs (buttons).
- Everything else stays in uart_rx.

Test Plan (CLKS_PER_BIT=8 unless noted):
- Reset behaviour: hold reset low 3 clks with rx idle → data=8'h00, ready=0, frame_err=0; release → no strobe for 200 clks.
- Single byte: send 8'h31 ("1") → exactly one ready pulse, data=8'h31; pulse ~79 clks after the start edge (±2).
- Back-to-back frames: send "1","2","2" with 1 stop bit and no gap → three ready pulses with data 8'h31, 8'h32, 8'h32 in order.
- Line faults:
  - 3-clk low glitch on idle rx → no ready, no frame_err.
  - Frame 8'h55 with stop bit forced 0 → frame_err pulse, data keeps previous value.
  - rx held low 100 clks → single frame_err, then 8'h32 received correctly.
- Reset mid-frame: assert reset during bit 4 of 8'hA5 → no strobe, data=8'h00; next frame 8'h31 received correctly.
- With UART_RX_PARITY_EN defined:
  - 8'h31 with parity 1 → ready.
  - Same byte with parity 0 → parity_err pulse, no ready.
  - Default CLKS_PER_BIT=104, byte 8'h7E → ready and data=8'h7E.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry, common to rx and tx.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Byte/strobe interface between the UART receiver (master) and a byte consumer (slave).
// UART_RX_PARITY_EN adds the parity_err strobe.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 ready;
    logic                 frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (input rx, output data, output ready, output frame_err, output parity_err);
    modport slave  (output rx, input data, input ready, input frame_err, input parity_err);
`else
    modport master (input rx, output data, output ready, output frame_err);
    modport slave  (output rx, input data, input ready, input frame_err);
`endif
endinterface

// File: rtl/rx_sync.sv
// Two-flop synchronizer for asynchronous board inputs; RESET_VAL sets the preset level.
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], async_i};
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: serial rx line to a parallel byte with ready / frame_err strobes.
// Define UART_RX_PARITY_EN for an even-parity bit after bit 7 and a parity_err strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);

    localparam int unsigned TW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [TW-1:0]    HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]    BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
    logic                 bit_end;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    // Preset to idle-high so releasing reset never looks like a start edge
    rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .rst_n   (reset),
        .async_i (bus.rx),
        .sync_o  (rx_s)
    );

    assign bit_end = (timer_q == BIT_LAST);

    // Next-state and strobe logic
    always_comb begin
        state_d = state_q;
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d[idx_q] = rx_s;
                    idx_d          = idx_q + IDX_W'(1);
`ifdef UART_RX_PARITY_EN
                    if (idx_q == IDX_LAST) state_d = PARITY;
`else
                    if (idx_q == IDX_LAST) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (rx_s) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shreg_q, par_q}) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d  = shreg_q;
                            ready_d = 1'b1;
                        end
`else
                        data_d  = shreg_q;
                        ready_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                timer_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.data      = data_q;
    assign bus.ready     = ready_q;
    assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: reset, table vectors, line faults, mid-frame reset, random frames.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CPB = 8;

    typedef enum int {EV_RDY, EV_FERR, EV_PERR} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] d;
        int         cyc;
    } ev_t;
    typedef struct {
        logic [7:0] b;
        bit         stop;
        bit         pflip;
        int         gap;
        ev_kind_e   kind;
        logic [7:0] d;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if ifc();
    uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (.clk(clk), .reset(rst_n), .bus(ifc));

`ifdef UART_RX_PARITY_EN
    uart_rx_if ifc104();
    uart_rx u_dut104 (.clk(clk), .reset(rst_n), .bus(ifc104));
`endif

    ev_t        mon_q[$];
    ev_t        exp_q[$];
    vec_t       tbl[$];
    int         cyc        = 0;
    int         compared   = 0;
    int         mismatched = 0;
    int         overlap    = 0;
    int         drift      = 0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] model_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect strobes and watch the output invariants
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.ready)     mon_q.push_back('{EV_RDY,  ifc.data, cyc});
            if (ifc.frame_err) mon_q.push_back('{EV_FERR, ifc.data, cyc});
            if (ifc.ready && ifc.frame_err) overlap++;
`ifdef UART_RX_PARITY_EN
            if (ifc.parity_err) mon_q.push_back('{EV_PERR, ifc.data, cyc});
            if (ifc.parity_err && (ifc.ready || ifc.frame_err)) overlap++;
`endif
            if (ifc.data !== prev_data && !ifc.ready) drift++;
        end
        prev_data = ifc.data;
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_t(input logic v);
        ifc.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int nbits);
        ifc.rx = 1'b1;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit pflip);
        bit_t(1'b0);
        for (int i = 0; i < 8; i++) bit_t(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_t(^b ^ pflip);
`else
        if (pflip) $display("note: parity flip ignored in 8N1 build");
`endif
        bit_t(stop);
        ifc.rx = 1'b1;
    endtask

    task automatic compare_events(input string tag);
        chk($sformatf("%s_count", tag), mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            chk($sformatf("%s_kind%0d", tag, i), int'(mon_q[i].kind), int'(exp_q[i].kind));
            chk($sformatf("%s_data%0d", tag, i), int'(mon_q[i].d), int'(exp_q[i].d));
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         t0;
        int         lat;
        logic [7:0] b;
        bit         stop;
        bit         pflip;

        ifc.rx = 1'b1;
`ifdef UART_RX_PARITY_EN
        ifc104.rx = 1'b1;
`endif
        tbl.push_back('{8'h31, 1'b1, 1'b0, 0, EV_RDY,  8'h31});
        tbl.push_back('{8'h32, 1'b1, 1'b0, 0, EV_RDY,  8'h32});
        tbl.push_back('{8'h32, 1'b1, 1'b0, 1, EV_RDY,  8'h32});
        tbl.push_back('{8'h55, 1'b0, 1'b0, 2, EV_FERR, 8'h32});
        tbl.push_back('{8'hA7, 1'b1, 1'b0, 0, EV_RDY,  8'hA7});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 1, EV_RDY,  8'h00});
        tbl.push_back('{8'hFF, 1'b1, 1'b0, 1, EV_RDY,  8'hFF});
`ifdef UART_RX_PARITY_EN
        tbl.push_back('{8'h31, 1'b1, 1'b0, 1, EV_RDY,  8'h31});
        tbl.push_back('{8'h31, 1'b1, 1'b1, 1, EV_PERR, 8'h31});
        tbl.push_back('{8'h5A, 1'b0, 1'b1, 2, EV_FERR, 8'h31});
`endif

        // Reset state, then a quiet line after release
        repeat (3) @(negedge clk);
        chk("reset_data", int'(ifc.data), 0);
        chk("reset_ready", int'(ifc.ready), 0);
        chk("reset_ferr", int'(ifc.frame_err), 0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        compare_events("reset_quiet");

        // Single byte with latency from the start edge
        t0 = cyc;
        send_frame(8'h31, 1'b1, 1'b0);
        idle(2);
        lat = (mon_q.size() > 0) ? mon_q[0].cyc - t0 : -1;
        compared++;
        if (lat < 77 || lat > 81) begin
            mismatched++;
            $display("FAIL single_latency: got %0d clks expected 79 +/- 2", lat);
        end
        exp_q.push_back('{EV_RDY, 8'h31, 0});
        model_data = 8'h31;
        compare_events("single");

        // Table vectors, sent back-to-back where gap is zero
        foreach (tbl[i]) begin
            send_frame(tbl[i].b, tbl[i].stop, tbl[i].pflip);
            idle(tbl[i].gap);
            exp_q.push_back('{tbl[i].kind, tbl[i].d, 0});
            model_data = tbl[i].d;
        end
        idle(2);
        compare_events("table");

        // Short glitch on the idle line
        ifc.rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(3);
        compare_events("glitch");

        // Held-low line: one frame error, then normal reception
        ifc.rx = 1'b0;
        repeat (100) @(negedge clk);
        idle(2);
        send_frame(8'h32, 1'b1, 1'b0);
        idle(2);
        exp_q.push_back('{EV_FERR, model_data, 0});
        exp_q.push_back('{EV_RDY, 8'h32, 0});
        model_data = 8'h32;
        compare_events("break");

        // Reset during bit 4 of 8'hA5
        b = 8'hA5;
        bit_t(1'b0);
        for (int i = 0; i < 4; i++) bit_t(b[i]);
        ifc.rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_data", int'(ifc.data), 0);
        chk("midreset_ready", int'(ifc.ready), 0);
        ifc.rx = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        idle(3);
        model_data = 8'h00;
        compare_events("midreset_quiet");
        send_frame(8'h31, 1'b1, 1'b0);
        idle(2);
        exp_q.push_back('{EV_RDY, 8'h31, 0});
        model_data = 8'h31;
        compare_events("midreset_next");

        // Random frames against the frame-level model
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
            pflip = ($urandom_range(0, 3) == 0);
`else
            pflip = 1'b0;
`endif
            send_frame(b, stop, pflip);
            if (!stop) begin
                exp_q.push_back('{EV_FERR, model_data, 0});
                idle(2);
            end else if (pflip) begin
                exp_q.push_back('{EV_PERR, model_data, 0});
                idle(int'($urandom_range(0, 1)));
            end else begin
                exp_q.push_back('{EV_RDY, b, 0});
                model_data = b;
                idle(int'($urandom_range(0, 1)));
            end
        end
        idle(2);
        compare_events("random");

`ifdef UART_RX_PARITY_EN
        // Default-rate instance: 8'h7E with even parity
        begin
            logic [10:0] fr;
            bit          got = 1'b0;
            logic [7:0]  gd  = 8'h00;
            b  = 8'h7E;
            fr = {1'b1, ^b, b, 1'b0};
            for (int i = 0; i < 11; i++) begin
                ifc104.rx = fr[i];
                repeat (DEFAULT_CLKS_PER_BIT) begin
                    @(negedge clk);
                    if (ifc104.ready && !got) begin
                        got = 1'b1;
                        gd  = ifc104.data;
                    end
                end
            end
            ifc104.rx = 1'b1;
            for (int i = 0; i < 400 && !got; i++) begin
                @(negedge clk);
                if (ifc104.ready) begin
                    got = 1'b1;
                    gd  = ifc104.data;
                end
            end
            chk("rate104_ready", int'(got), 1);
            chk("rate104_data", int'(gd), 8'h7E);
        end
`endif

        chk("strobe_overlap", overlap, 0);
        chk("data_held", drift, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
